// File: rtl/audio_capture_recorder_pkg.sv
// Shared audio types and widths for the capture and playback paths.
// Package audio_pkg: recorder state encoding and the stored sample layout.
package audio_pkg;

    localparam int AUDIO_ADDR_W  = 14;
    localparam int AUDIO_DATA_W  = 6;
    localparam int AUDIO_CODEC_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RECORD,
        DONE
    } audio_state_t;

endpackage

// File: rtl/audio_capture_recorder_if.sv
// Audio_Controller input FIFO handshake plus the sample RAM write port.
// master = recorder side, slave = codec FIFO / RAM side.
interface audio_capture_recorder_if
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W
);

    logic                     audio_in_available;
    logic [AUDIO_CODEC_W-1:0] left_channel_audio_in;
    logic [AUDIO_CODEC_W-1:0] right_channel_audio_in;
    logic                     read_audio_in;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wren;

    modport master (
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in,
        output wr_addr,
        output wr_data,
        output wren
    );

    modport slave (
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in,
        input  wr_addr,
        input  wr_data,
        input  wren
    );

endinterface

// File: rtl/audio_capture_recorder_mixer.sv
// Stereo-to-mono mix and truncation to the stored sample width.
// Magnitude output exists only with AUDIO_CAPTURE_VOICE_TRIGGER_EN.
module audio_sample_mixer
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W
)(
    input  logic [AUDIO_CODEC_W-1:0] left,
    input  logic [AUDIO_CODEC_W-1:0] right,
    output logic [DATA_W-1:0]        sample
`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
    ,
    output logic [DATA_W-1:0]        mag
`endif
);

    logic signed [AUDIO_CODEC_W-1:0] l_s;
    logic signed [AUDIO_CODEC_W-1:0] r_s;
    logic signed [AUDIO_CODEC_W-1:0] mix;

    assign l_s = left;
    assign r_s = right;
    // halving each channel first keeps the sum inside 32 bits
    assign mix = (l_s >>> 1) + (r_s >>> 1);
    assign sample = DATA_W'(mix >>> (AUDIO_CODEC_W - DATA_W));

`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    always_comb begin
        mag = sample;
        if (sample == S_MIN)
            mag = ~S_MIN;
        else if (sample[DATA_W-1])
            mag = -sample;
    end
`endif

endmodule

// File: rtl/audio_capture_recorder.sv
// Microphone capture into a 2**ADDR_W x DATA_W sample RAM.
// Voice-triggered arming is enabled by AUDIO_CAPTURE_VOICE_TRIGGER_EN.
module audio_capture_recorder
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int DECIM  = 1
`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
    ,
    parameter logic [DATA_W-1:0] THRESH = 6'd8
`endif
)(
    input  logic                      CLOCK_50,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      stop,
    audio_capture_recorder_if.master  aud,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           rec_len
);

    localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
    localparam audio_state_t ENTRY = ARMED;
`else
    localparam audio_state_t ENTRY = RECORD;
`endif

    audio_state_t      state;
    audio_state_t      state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_n;
    logic [7:0]        dcnt_q;
    logic [7:0]        dcnt_n;
    logic              wren_q;
    logic              wren_n;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_n;
    logic [DATA_W-1:0] sample;
    logic              last;
    logic              full;
    logic              avail;

`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
    logic [DATA_W-1:0] mag;
`endif

    audio_sample_mixer #(
        .DATA_W (DATA_W)
    ) u_mix (
        .left   (aud.left_channel_audio_in),
        .right  (aud.right_channel_audio_in),
        .sample (sample)
`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
        ,
        .mag    (mag)
`endif
    );

    assign avail = aud.audio_in_available;
    assign last  = (addr_q == '1);
    // in-flight write to the top address ends the recording
    assign full  = wren_q && last;

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        len_n   = len_q;
        dcnt_n  = dcnt_q;
        wren_n  = 1'b0;
        data_n  = data_q;

        if (wren_q) begin
            len_n = len_q + 1'b1;
            if (!last)
                addr_n = addr_q + 1'b1;
        end

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = ENTRY;
                    addr_n  = '0;
                    len_n   = '0;
                    dcnt_n  = '0;
                end
            end
`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
            ARMED: begin
                if (stop) begin
                    state_n = DONE;
                end else if (avail && mag >= THRESH) begin
                    state_n = RECORD;
                    wren_n  = 1'b1;
                    data_n  = sample;
                    dcnt_n  = (DEC_LAST == 8'd0) ? 8'd0 : 8'd1;
                end
            end
`endif
            RECORD: begin
                if (avail && !full) begin
                    if (dcnt_q == 8'd0) begin
                        wren_n = 1'b1;
                        data_n = sample;
                    end
                    dcnt_n = (dcnt_q == DEC_LAST) ? 8'd0 : dcnt_q + 8'd1;
                end
                if (stop || full)
                    state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            dcnt_q <= '0;
            wren_q <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_n;
            addr_q <= addr_n;
            len_q  <= len_n;
            dcnt_q <= dcnt_n;
            wren_q <= wren_n;
            data_q <= data_n;
        end
    end

    assign aud.read_audio_in = avail;
    assign aud.wr_addr       = addr_q;
    assign aud.wr_data       = data_q;
    assign aud.wren          = wren_q;
    assign busy    = (state == ARMED) || (state == RECORD);
    assign done    = (state == DONE);
    assign rec_len = len_q;

endmodule

// File: tb/tb_audio_capture_recorder.sv
// Scoreboard bench: default, 4-bit-address and DECIM=3 recorders.
// Voice-trigger case runs only with AUDIO_CAPTURE_VOICE_TRIGGER_EN.
module tb_audio_capture_recorder;
    import audio_pkg::*;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic resetn;
    logic stop;
    logic start0, start1, start2;
    logic busy0, done0, busy1, done1, busy2, done2;
    logic [14:0] len0;
    logic [4:0]  len1;
    logic [14:0] len2;

    audio_capture_recorder_if #(.ADDR_W(14), .DATA_W(6)) if0 ();
    audio_capture_recorder_if #(.ADDR_W(4),  .DATA_W(6)) if1 ();
    audio_capture_recorder_if #(.ADDR_W(14), .DATA_W(6)) if2 ();

    audio_capture_recorder #(.ADDR_W(14), .DATA_W(6), .DECIM(1)) u0 (
        .CLOCK_50 (clk), .resetn (resetn), .start (start0), .stop (stop),
        .aud (if0), .busy (busy0), .done (done0), .rec_len (len0)
    );

    audio_capture_recorder #(.ADDR_W(4), .DATA_W(6), .DECIM(1)) u1 (
        .CLOCK_50 (clk), .resetn (resetn), .start (start1), .stop (stop),
        .aud (if1), .busy (busy1), .done (done1), .rec_len (len1)
    );

    audio_capture_recorder #(.ADDR_W(14), .DATA_W(6), .DECIM(3)) u2 (
        .CLOCK_50 (clk), .resetn (resetn), .start (start2), .stop (stop),
        .aud (if2), .busy (busy2), .done (done2), .rec_len (len2)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {addr[13:0], data[5:0]}
    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] q2[$];
    logic [19:0] e0, e1, e2;
    int wc0 = 0;
    int wc1 = 0;
    int wc2 = 0;

    always @(negedge clk) begin
        if (if0.wren === 1'b1) begin
            wc0++;
            if (q0.size() == 0) begin
                chk("u0_extra_wren", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("u0_addr", 32'(if0.wr_addr), 32'(e0[19:6]));
                chk("u0_data", 32'(if0.wr_data), 32'(e0[5:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (if1.wren === 1'b1) begin
            wc1++;
            if (q1.size() == 0) begin
                chk("u1_extra_wren", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("u1_addr", 32'(if1.wr_addr), 32'(e1[19:6]));
                chk("u1_data", 32'(if1.wr_data), 32'(e1[5:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (if2.wren === 1'b1) begin
            wc2++;
            if (q2.size() == 0) begin
                chk("u2_extra_wren", 32'd1, 32'd0);
            end else begin
                e2 = q2.pop_front();
                chk("u2_addr", 32'(if2.wr_addr), 32'(e2[19:6]));
                chk("u2_data", 32'(if2.wr_data), 32'(e2[5:0]));
            end
        end
    end

    function automatic logic [31:0] top6(logic [5:0] v);
        return {v, 26'b0};
    endfunction

    task automatic set_in(bit av, logic [31:0] l, logic [31:0] r);
        if0.audio_in_available = av;
        if0.left_channel_audio_in = l;
        if0.right_channel_audio_in = r;
        if1.audio_in_available = av;
        if1.left_channel_audio_in = l;
        if1.right_channel_audio_in = r;
        if2.audio_in_available = av;
        if2.left_channel_audio_in = l;
        if2.right_channel_audio_in = r;
    endtask

    task automatic drv(bit av, logic [31:0] l, logic [31:0] r);
        set_in(av, l, r);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int which);
        start0 = (which == 0);
        start1 = (which == 1);
        start2 = (which == 2);
        drv(1'b0, 32'h0, 32'h0);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        drv(1'b0, 32'h0, 32'h0);
        stop = 1'b0;
    endtask

    logic [5:0] dec_exp [3];

    initial begin
        dec_exp[0] = 6'd15;
        dec_exp[1] = 6'd16;
        dec_exp[2] = 6'd18;
        resetn = 1'b0;
        stop   = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        set_in(1'b1, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wren", 32'(if0.wren), 32'd0);
        chk("rst_addr", 32'(if0.wr_addr), 32'd0);
        chk("rst_data", 32'(if0.wr_data), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_len", 32'(len0), 32'd0);
        chk("rst_read", 32'(if0.read_audio_in), 32'd1);
        drv(1'b0, 32'h0, 32'h0);
        resetn = 1'b1;
        drv(1'b0, 32'h0, 32'h0);

        // stop from IDLE does nothing
        pulse_stop();
        @(negedge clk);
        chk("idle_stop_done", 32'(done0), 32'd0);
        chk("idle_stop_busy", 32'(busy0), 32'd0);

        // five loud samples
        pulse_start(0);
        @(negedge clk);
        chk("t1_busy_start", 32'(busy0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            q0.push_back({14'(i), 6'h1F});
            drv(1'b1, 32'h7C000000, 32'h7C000000);
        end
        drv(1'b0, 32'h0, 32'h0);
        drv(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_len", 32'(len0), 32'd5);
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_wc", 32'(wc0), 32'd5);
        chk("t1_q", 32'(q0.size()), 32'd0);
        pulse_stop();
        @(negedge clk);
        chk("t1_done", 32'(done0), 32'd1);
        chk("t1_idle_busy", 32'(busy0), 32'd0);

        // fill a 16-entry RAM with a continuous stream
        pulse_start(1);
        for (int k = 0; k < 20; k++) begin
            if (k < 16)
                q1.push_back({14'(k), 6'(k + 10)});
            drv(1'b1, top6(6'(k + 10)), top6(6'(k + 10)));
        end
        drv(1'b0, 32'h0, 32'h0);
        drv(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t2_done", 32'(done1), 32'd1);
        chk("t2_len", 32'(len1), 32'd16);
        chk("t2_wc", 32'(wc1), 32'd16);
        chk("t2_addr", 32'(if1.wr_addr), 32'd15);
        chk("t2_q", 32'(q1.size()), 32'd0);

        // keep one sample in three
        pulse_start(2);
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0)
                q2.push_back({14'(i / 3), dec_exp[i / 3]});
            drv(1'b1, top6(6'(20 + i)), top6(6'd10));
        end
        drv(1'b0, 32'h0, 32'h0);
        drv(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t3_len", 32'(len2), 32'd3);
        chk("t3_wc", 32'(wc2), 32'd3);
        chk("t3_q", 32'(q2.size()), 32'd0);
        pulse_stop();

        // restart from DONE, stop together with the 4th sample
        pulse_start(0);
        @(negedge clk);
        chk("t4_len_clr", 32'(len0), 32'd0);
        q0.push_back({14'd0, 6'h31});
        drv(1'b1, top6(6'h2C), top6(6'h36));
        q0.push_back({14'd1, 6'h3F});
        drv(1'b1, 32'hFFFFFFFF, 32'h00000001);
        q0.push_back({14'd2, 6'h1F});
        drv(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF);
        q0.push_back({14'd3, 6'h20});
        stop = 1'b1;
        drv(1'b1, 32'h80000000, 32'h80000000);
        stop = 1'b0;
        set_in(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_done", 32'(done0), 32'd1);
        chk("t4_wren", 32'(if0.wren), 32'd1);
        drv(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_len", 32'(len0), 32'd4);
        chk("t4_wc", 32'(wc0), 32'd9);
        pulse_start(0);
        @(negedge clk);
        chk("t4_restart_len", 32'(len0), 32'd0);
        chk("t4_restart_busy", 32'(busy0), 32'd1);

        // reset while the 8th write is in flight
        for (int i = 0; i < 8; i++) begin
            if (i < 7)
                q0.push_back({14'(i), 6'h1F});
            drv(1'b1, 32'h7C000000, 32'h7C000000);
        end
        chk("t5_len", 32'(len0), 32'd7);
        chk("t5_inflight", 32'(if0.wren), 32'd1);
        q0.push_back({14'd7, 6'h1F});
        resetn = 1'b0;
        #1;
        chk("t5_wren", 32'(if0.wren), 32'd0);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_rlen", 32'(len0), 32'd0);
        chk("t5_read_hi", 32'(if0.read_audio_in), 32'd1);
        void'(q0.pop_back());
        set_in(1'b0, 32'h0, 32'h0);
        #1;
        chk("t5_read_lo", 32'(if0.read_audio_in), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drv(1'b0, 32'h0, 32'h0);

`ifdef AUDIO_CAPTURE_VOICE_TRIGGER_EN
        pulse_start(0);
        @(negedge clk);
        chk("vt_armed_busy", 32'(busy0), 32'd1);
        drv(1'b1, top6(6'd3), top6(6'd3));
        drv(1'b1, top6(6'h3C), top6(6'h3C));
        q0.push_back({14'd0, 6'd9});
        drv(1'b1, top6(6'd9), top6(6'd9));
        drv(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("vt_len", 32'(len0), 32'd1);
        pulse_stop();
`endif

        drv(1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("end_q0", 32'(q0.size()), 32'd0);
        chk("end_q1", 32'(q1.size()), 32'd0);
        chk("end_q2", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_capture_recorder.md
Name: audio_capture_recorder

Overview:
- Capture-side counterpart of the ROM playback path: consumes microphone samples from Audio_Controller's input FIFO handshake and writes them into a write-enabled sample RAM.
- Stored format: 6-bit samples, 14-bit address, the same layout the playback path reads.
- Sits between Audio_Controller (audio_in_available / left/right_channel_audio_in / read_audio_in) and a 16384x6 single-port RAM.
- Controlled by start/stop pulses from the top level; reports busy, done and the recorded length.

Parameters:
- ADDR_W, 14, RAM address width; depth = 2**ADDR_W.
- DATA_W, 6, stored sample width; the top DATA_W bits of the mixed sample.
- DECIM, 1, keep 1 of every DECIM accepted samples (1..255).
- THRESH, 6'd8, magnitude threshold used only with VOICE_TRIGGER_EN.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a recording from IDLE or DONE.
- stop  in  1  one-cycle pulse; ends a recording early.
- audio_in_available  in  1  Audio_Controller input FIFO non-empty.
- left_channel_audio_in  in  32  signed left sample, valid while available.
- right_channel_audio_in  in  32  signed right sample, valid while available.
- read_audio_in  out  1  FIFO pop; combinationally equal to audio_in_available.
- wr_addr  out  ADDR_W  RAM address.
- wr_data  out  DATA_W  RAM data.
- wren  out  1  RAM write strobe, one cycle per stored sample.
- busy  out  1  high in ARMED or RECORD.
- done  out  1  high in DONE.
- rec_len  out  ADDR_W+1  number of samples written in the last or current recording.

Behaviour:
- Reset (async, resetn=0) sets:
  - state=IDLE; wr_addr=0, wr_data=0, wren=0, busy=0, done=0, rec_len=0.
  - Decimation counter = 0.
- FIFO draining:
  - read_audio_in = audio_in_available in every state, so the FIFO never stalls.
  - A sample is "accepted" on any cycle where audio_in_available=1.
- Mixing:
  - mix = (L >>> 1) + (R >>> 1), signed 32-bit, no overflow possible.
  - sample = mix[31:32-DATA_W].
- States:
  - IDLE: start -> RECORD (ARMED if VOICE_TRIGGER_EN). On entry, wr_addr, rec_len and the decimation counter clear. stop is ignored.
  - RECORD: each accepted sample with decim counter == 0 is registered. On the next cycle wren=1 with wr_data=sample and wr_addr = current address. The address then increments and rec_len increments on that same edge. The decimation counter counts 0..DECIM-1 per accepted sample and wraps.
  - DONE: done=1 and outputs are held. start -> same entry as from IDLE; stop is ignored.
- Write latency: 1 cycle from accept to wren.
- Full condition: the write to address 2**ADDR_W-1 makes rec_len = 2**ADDR_W. The state moves to DONE on that edge and the address does not wrap.
- stop in RECORD -> DONE on the next edge.
  - If stop coincides with an accepted sample, that sample's write still completes (wren one cycle later) and is counted.
  - Any write already in flight always completes.
- start while busy is ignored; start and stop in the same cycle in IDLE/DONE -> start wins.
- Reset mid-recording: immediate return to IDLE; rec_len is lost.

Optional Feature:
- Macro: AUDIO_CAPTURE_VOICE_TRIGGER_EN.
- Defined: start -> ARMED.
  - In ARMED, samples are drained but not stored.
  - The first accepted sample with |sample| >= THRESH (DATA_W-bit two's-complement magnitude, -32 saturates to 31) moves to RECORD, and that sample is the first stored.
  - stop in ARMED -> DONE with rec_len=0.
- Not defined: the ARMED state and THRESH logic are absent; start goes straight to RECORD.

Decomposition:
- Shared package audio_pkg holds:
  - The state enum (IDLE, ARMED, RECORD, DONE).
  - Constants AUDIO_ADDR_W=14 and AUDIO_DATA_W=6, also used by the playback side.
  - The codec sample width of 32.
- One natural sub-module, audio_sample_mixer: mixes, truncates and computes the magnitude; purely combinational.
- FSM, counters and RAM interface stay in the top.

Test Plan:
- Reset, then start, then 5 samples L=R=32'h7C000000 -> 5 wren pulses, addr 0..4, wr_data=6'h1F, rec_len=5, busy=1.
- Continuous samples with ADDR_W overridden to 4 -> exactly 16 writes, last at addr 15, then done=1, rec_len=16, no 17th wren.
- DECIM=3, 9 accepted samples -> writes only for samples 0, 3 and 6; rec_len=3.
- stop in the same cycle as the 4th accepted sample -> 4th write occurs, rec_len=4, DONE next cycle; a following start clears rec_len to 0.
- resetn low mid-record at rec_len=7 -> wren=0 and state IDLE immediately; read_audio_in still tracks audio_in_available.
- With VOICE_TRIGGER_EN, THRESH=8: samples 6'd3, 6'h3C (-4), then 6'd9 -> the first write carries 9 at addr 0.
